// File: rtl/pipeline_stall_controller_if.sv
// rtl/pipeline_stall_controller_if.sv - hazard inputs and stage-control outputs of the stall controller
interface pipeline_stall_controller_if;
    // hazard / wait indications from the pipeline
    logic        load_use;
    logic        redirect;
    logic        id_is_md;
    logic        id_is_div;
    logic        id_uses_hilo;
    logic        imem_wait;
    logic        dmem_wait;

    // per-stage controls back to the pipeline
    logic        PC_Write;
    logic        ifId_Write;
    logic        ifId_Flush;
    logic        idEx_Bubble;
    logic        back_Write;
    logic        md_issue;
    logic        md_busy;
    logic [15:0] stall_cycles;

    // pipeline side: drives hazards, consumes controls
    modport master (
        output load_use, redirect, id_is_md, id_is_div, id_uses_hilo, imem_wait, dmem_wait,
        input  PC_Write, ifId_Write, ifId_Flush, idEx_Bubble, back_Write, md_issue, md_busy,
               stall_cycles
    );

    // controller side
    modport slave (
        input  load_use, redirect, id_is_md, id_is_div, id_uses_hilo, imem_wait, dmem_wait,
        output PC_Write, ifId_Write, ifId_Flush, idEx_Bubble, back_Write, md_issue, md_busy,
               stall_cycles
    );
endinterface

// File: rtl/pipeline_stall_controller.sv
// rtl/pipeline_stall_controller.sv - stall/flush sequencer with mult/div occupancy and stall counter
module pipeline_stall_controller #(
    parameter int MUL_LATENCY = 4,
    parameter int DIV_LATENCY = 32,
    parameter int CNT_W       = 6
) (
    input  logic                        clk,
    input  logic                        reset,
    pipeline_stall_controller_if.slave  bus
);

    // Operating mode for the current cycle, highest priority first.
    typedef enum logic [2:0] {
        MODE_RESET    = 3'd0,
        MODE_FREEZE   = 3'd1,
        MODE_STALL    = 3'd2,
        MODE_REDIRECT = 3'd3,
        MODE_RUN      = 3'd4
    } mode_t;

    // Counter reload values: busy covers the L-1 cycles after the issue cycle.
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LATENCY - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LATENCY - 1);
    localparam logic [15:0]      STALL_MAX = 16'hFFFF;

    logic [CNT_W-1:0] r_md_count;
    logic [15:0]      r_stall_cycles;

    mode_t            w_mode;
    logic             w_md_busy;
    logic             w_fs;
    logic             w_md_issue;
    logic             w_pc_write;
    logic             w_ifid_write;
    logic             w_ifid_flush;
    logic             w_idex_bubble;
    logic             w_back_write;

    assign w_md_busy = (r_md_count != '0);

    // Front stall: IF/ID must hold while a load result, the mult/div unit or imem is not ready.
    assign w_fs = bus.load_use
                | (w_md_busy & (bus.id_is_md | bus.id_uses_hilo))
                | bus.imem_wait;

    // A new mult/div op may only start when the unit is idle and ID actually advances.
    assign w_md_issue = bus.id_is_md & ~w_md_busy & ~w_fs & ~bus.dmem_wait & ~reset;

    // Select the cycle's mode; a redirect during freeze or stall is simply not acted on,
    // ID keeps the branch and it is re-evaluated once the pipeline moves again.
    always_comb begin
        w_mode = MODE_RUN;
        if (reset) begin
            w_mode = MODE_RESET;
        end else if (bus.dmem_wait) begin
            w_mode = MODE_FREEZE;
        end else if (w_fs) begin
            w_mode = MODE_STALL;
        end else if (bus.redirect) begin
            w_mode = MODE_REDIRECT;
        end
    end

    // Decode the mode into per-stage write enables, flush and bubble.
    always_comb begin
        w_pc_write    = 1'b1;
        w_ifid_write  = 1'b1;
        w_ifid_flush  = 1'b0;
        w_idex_bubble = 1'b0;
        w_back_write  = 1'b1;
        case (w_mode)
            MODE_RESET: begin
                w_pc_write    = 1'b0;
                w_ifid_write  = 1'b0;
                w_ifid_flush  = 1'b1;
                w_idex_bubble = 1'b1;
                w_back_write  = 1'b0;
            end
            MODE_FREEZE: begin
                w_pc_write    = 1'b0;
                w_ifid_write  = 1'b0;
                w_back_write  = 1'b0;
            end
            MODE_STALL: begin
                w_pc_write    = 1'b0;
                w_ifid_write  = 1'b0;
                w_idex_bubble = 1'b1;
            end
            MODE_REDIRECT: begin
                w_ifid_flush  = 1'b1;
            end
            default: begin
                w_pc_write    = 1'b1;
            end
        endcase
    end

    // Occupancy down-counter: loads on issue, then counts down regardless of stalls or freezes.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_md_count <= '0;
        end else if (w_md_issue) begin
            r_md_count <= bus.id_is_div ? DIV_LOAD : MUL_LOAD;
        end else if (w_md_busy) begin
            r_md_count <= r_md_count - 1'b1;
        end
    end

    // Saturating count of cycles in which the PC did not advance (reset cycles excluded).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cycles <= '0;
        end else if (!w_pc_write && (r_stall_cycles != STALL_MAX)) begin
            r_stall_cycles <= r_stall_cycles + 16'd1;
        end
    end

    assign bus.PC_Write     = w_pc_write;
    assign bus.ifId_Write   = w_ifid_write;
    assign bus.ifId_Flush   = w_ifid_flush;
    assign bus.idEx_Bubble  = w_idex_bubble;
    assign bus.back_Write   = w_back_write;
    assign bus.md_issue     = w_md_issue;
    assign bus.md_busy      = w_md_busy;
    assign bus.stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// tb/tb_pipeline_stall_controller.sv - randomized and directed bench for pipeline_stall_controller
module tb_pipeline_stall_controller;

    localparam int MUL_L = 4;
    localparam int DIV_L = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipeline_stall_controller_if bus();

    pipeline_stall_controller #(
        .MUL_LATENCY(MUL_L),
        .DIV_LATENCY(DIV_L),
        .CNT_W(6)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    // reference model: the mult/div op is a time window [issue+1, issue+L-1] in absolute cycles
    int  m_cyc = 0;
    int  m_op_end = 0;
    bit  m_have_op = 0;
    int  m_stalls = 0;
    bit  c_rst, c_div;
    logic e_pc, e_ifid, e_flush, e_bubble, e_back, e_issue, e_busy;

    task automatic model_comb(input bit rst, lu, rd, md, dv, hl, iw, dw);
        bit fs;
        e_busy = m_have_op && (m_cyc <= m_op_end);
        fs = lu || (e_busy && (md || hl)) || iw;
        if (rst) begin
            {e_pc, e_ifid, e_flush, e_bubble, e_back} = 5'b00110;
        end else if (dw) begin
            {e_pc, e_ifid, e_flush, e_bubble, e_back} = 5'b00000;
        end else if (fs) begin
            {e_pc, e_ifid, e_flush, e_bubble, e_back} = 5'b00011;
        end else if (rd) begin
            {e_pc, e_ifid, e_flush, e_bubble, e_back} = 5'b11101;
        end else begin
            {e_pc, e_ifid, e_flush, e_bubble, e_back} = 5'b11001;
        end
        e_issue = md && !e_busy && !fs && !dw && !rst;
        c_rst = rst;
        c_div = dv;
    endtask

    task automatic cyc_begin(input bit rst, lu, rd, md, dv, hl, iw, dw);
        reset            = rst;
        bus.load_use     = lu;
        bus.redirect     = rd;
        bus.id_is_md     = md;
        bus.id_is_div    = dv;
        bus.id_uses_hilo = hl;
        bus.imem_wait    = iw;
        bus.dmem_wait    = dw;
        model_comb(rst, lu, rd, md, dv, hl, iw, dw);
        #2;
    endtask

    task automatic cyc_end();
        @(posedge clk);
        if (c_rst) begin
            m_have_op = 0;
            m_stalls  = 0;
        end else begin
            if (e_issue) begin
                m_have_op = 1;
                m_op_end  = m_cyc + (c_div ? DIV_L : MUL_L) - 1;
            end
            if (!e_pc && m_stalls < 65535) m_stalls++;
        end
        m_cyc++;
        #1;
    endtask

    task automatic idle();
        cyc_begin(0, 0, 0, 0, 0, 0, 0, 0);
        cyc_end();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            cyc_begin(1, 0, 0, 0, 0, 0, 0, 1);
            checks++;
            if ({bus.PC_Write, bus.ifId_Write, bus.ifId_Flush, bus.idEx_Bubble, bus.back_Write, bus.md_issue} !== 6'b001100) begin
                errors++;
                $display("FAIL reset_outputs cyc%0d: got %b expected 001100", i,
                         {bus.PC_Write, bus.ifId_Write, bus.ifId_Flush, bus.idEx_Bubble, bus.back_Write, bus.md_issue});
            end
            cyc_end();
        end
        cyc_begin(0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (bus.md_busy !== 1'b0 || bus.stall_cycles !== 16'd0) begin
            errors++;
            $display("FAIL reset_state: md_busy=%b stall_cycles=%0d expected 0/0", bus.md_busy, bus.stall_cycles);
        end
        checks++;
        if ({bus.PC_Write, bus.ifId_Write, bus.ifId_Flush, bus.idEx_Bubble, bus.back_Write} !== 5'b11001) begin
            errors++;
            $display("FAIL reset_release_enables: got %b expected 11001",
                     {bus.PC_Write, bus.ifId_Write, bus.ifId_Flush, bus.idEx_Bubble, bus.back_Write});
        end
        cyc_end();
    endtask

    task automatic test_load_use_redirect();
        cyc_begin(0, 1, 1, 0, 0, 0, 0, 0);
        checks++;
        if ({bus.PC_Write, bus.ifId_Write, bus.idEx_Bubble, bus.ifId_Flush} !== 4'b0010) begin
            errors++;
            $display("FAIL lu_redirect_stall: got %b expected 0010",
                     {bus.PC_Write, bus.ifId_Write, bus.idEx_Bubble, bus.ifId_Flush});
        end
        cyc_end();
        cyc_begin(0, 0, 1, 0, 0, 0, 0, 0);
        checks++;
        if (bus.ifId_Flush !== 1'b1 || bus.PC_Write !== 1'b1) begin
            errors++;
            $display("FAIL lu_redirect_flush: flush=%b pc=%b expected 1/1", bus.ifId_Flush, bus.PC_Write);
        end
        checks++;
        if (bus.stall_cycles !== 16'd1) begin
            errors++;
            $display("FAIL lu_stall_count: got %0d expected 1", bus.stall_cycles);
        end
        cyc_end();
    endtask

    task automatic test_mult_hilo();
        int issues, pc_low, busy_n, release_at;
        issues = 0; pc_low = 0; busy_n = 0; release_at = -1;
        cyc_begin(0, 0, 0, 1, 0, 0, 0, 0);
        if (bus.md_issue === 1'b1) issues++;
        cyc_end();
        for (int i = 0; i < 6; i++) begin
            cyc_begin(0, 0, 0, 0, 0, 1, 0, 0);
            if (bus.md_issue === 1'b1) issues++;
            if (bus.PC_Write === 1'b0) pc_low++;
            if (bus.md_busy === 1'b1) busy_n++;
            if (bus.PC_Write === 1'b1 && release_at < 0) release_at = i;
            cyc_end();
        end
        checks++;
        if (issues !== 1) begin errors++; $display("FAIL mult_issue_pulses: got %0d expected 1", issues); end
        checks++;
        if (busy_n !== 3) begin errors++; $display("FAIL mult_busy_cycles: got %0d expected 3", busy_n); end
        checks++;
        if (pc_low !== 3 || release_at !== 3) begin
            errors++;
            $display("FAIL mult_hilo_stall: pc_low=%0d release_at=%0d expected 3/3", pc_low, release_at);
        end
    endtask

    task automatic test_div_freeze();
        int busy_n, last_busy, back_bad;
        busy_n = 0; last_busy = -1; back_bad = 0;
        cyc_begin(0, 0, 0, 1, 1, 0, 0, 0);
        checks++;
        if (bus.md_issue !== 1'b1) begin errors++; $display("FAIL div_issue: got %b expected 1", bus.md_issue); end
        cyc_end();
        for (int i = 0; i < 40; i++) begin
            cyc_begin(0, 0, 0, 0, 0, 0, 0, i < 10);
            if (bus.md_busy === 1'b1) begin busy_n++; last_busy = i; end
            if (bus.back_Write !== ((i < 10) ? 1'b0 : 1'b1)) back_bad++;
            cyc_end();
        end
        checks++;
        if (busy_n !== 31 || last_busy !== 30) begin
            errors++;
            $display("FAIL div_busy_window: busy=%0d last=%0d expected 31/30", busy_n, last_busy);
        end
        checks++;
        if (back_bad !== 0) begin errors++; $display("FAIL div_back_write: %0d bad cycles expected 0", back_bad); end
    endtask

    task automatic test_md_reissue();
        int issues, issue_at, busy_after;
        bit pending;
        issues = 0; issue_at = -1; busy_after = 0; pending = 1;
        cyc_begin(0, 0, 0, 1, 0, 0, 0, 0);
        cyc_end();
        for (int i = 0; i < 45; i++) begin
            cyc_begin(0, 0, 0, pending, 1, 0, 0, 0);
            if (bus.md_issue === 1'b1) begin issues++; issue_at = i; pending = 0; end
            else if (issue_at >= 0 && bus.md_busy === 1'b1) busy_after++;
            cyc_end();
        end
        checks++;
        if (issues !== 1 || issue_at !== 3) begin
            errors++;
            $display("FAIL reissue_timing: issues=%0d at=%0d expected 1/3", issues, issue_at);
        end
        checks++;
        if (busy_after !== 31) begin errors++; $display("FAIL reissue_latency: busy=%0d expected 31", busy_after); end
    endtask

    task automatic test_reset_mid_div();
        cyc_begin(0, 0, 0, 1, 1, 0, 0, 0);
        cyc_end();
        for (int i = 0; i < 5; i++) idle();
        cyc_begin(1, 0, 0, 0, 0, 0, 0, 0);
        cyc_end();
        cyc_begin(0, 0, 0, 0, 0, 1, 0, 0);
        checks++;
        if (bus.md_busy !== 1'b0 || bus.PC_Write !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_div: md_busy=%b pc=%b expected 0/1", bus.md_busy, bus.PC_Write);
        end
        cyc_end();
    endtask

    task automatic test_random();
        for (int i = 0; i < 500; i++) begin
            cyc_begin(($urandom % 50) == 0, ($urandom % 5) == 0, ($urandom % 4) == 0,
                      ($urandom % 4) == 0, $urandom % 2, ($urandom % 3) == 0,
                      ($urandom % 8) == 0, ($urandom % 7) == 0);
            checks++;
            if ({bus.PC_Write, bus.ifId_Write, bus.ifId_Flush, bus.idEx_Bubble, bus.back_Write} !==
                {e_pc, e_ifid, e_flush, e_bubble, e_back}) begin
                errors++;
                $display("FAIL rand_enables cyc%0d: got %b expected %b", i,
                         {bus.PC_Write, bus.ifId_Write, bus.ifId_Flush, bus.idEx_Bubble, bus.back_Write},
                         {e_pc, e_ifid, e_flush, e_bubble, e_back});
            end
            checks++;
            if (!c_rst && (bus.md_issue !== e_issue || bus.md_busy !== e_busy)) begin
                errors++;
                $display("FAIL rand_md cyc%0d: issue=%b busy=%b expected %b/%b", i,
                         bus.md_issue, bus.md_busy, e_issue, e_busy);
            end
            checks++;
            if (bus.stall_cycles !== 16'(m_stalls)) begin
                errors++;
                $display("FAIL rand_stall_count cyc%0d: got %0d expected %0d", i, bus.stall_cycles, m_stalls);
            end
            cyc_end();
        end
    endtask

    task automatic test_saturation();
        cyc_begin(1, 0, 0, 0, 0, 0, 0, 0);
        cyc_end();
        for (int i = 0; i < 65535; i++) begin
            cyc_begin(0, 0, 0, 0, 0, 0, 0, 1);
            cyc_end();
        end
        cyc_begin(0, 0, 0, 0, 0, 0, 0, 1);
        checks++;
        if (bus.stall_cycles !== 16'hFFFF) begin
            errors++;
            $display("FAIL sat_reach: got %h expected ffff", bus.stall_cycles);
        end
        cyc_end();
        for (int i = 0; i < 4; i++) begin
            cyc_begin(0, 0, 0, 0, 0, 0, 0, 1);
            cyc_end();
        end
        cyc_begin(0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (bus.stall_cycles !== 16'hFFFF || m_stalls != 65535) begin
            errors++;
            $display("FAIL sat_hold: got %h model %0d expected ffff", bus.stall_cycles, m_stalls);
        end
        cyc_end();
    endtask

    initial begin
        test_reset();
        test_load_use_redirect();
        idle();
        test_mult_hilo();
        idle();
        test_div_freeze();
        test_md_reissue();
        test_reset_mid_div();
        test_random();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
Central stall/flush sequencer for the 5-stage pipeline. It merges the load-use hazard indication, branch/jump redirects, data/instruction memory wait and an iterative multiply/divide occupancy tracker, and produces one consistent set of per-stage write enables, bubble and flush controls. It also issues start pulses to the shared iterative mult/div unit and keeps a saturating stall-cycle counter.

Parameters:
MUL_LATENCY, 4, cycles the iterative unit needs for MULT/MULTU (must be >=2)
DIV_LATENCY, 32, cycles the iterative unit needs for DIV/DIVU (must be >=2)
CNT_W, 6, width of the occupancy down-counter (must hold DIV_LATENCY-1)

Ports:
clk  input  1  pipeline clock, all state updates on rising edge
reset  input  1  synchronous, active-high
load_use  input  1  load-use hazard present this cycle (1 = hazard)
redirect  input  1  taken branch, J or JR resolved in ID
id_is_md  input  1  instruction in ID is MULT/MULTU/DIV/DIVU
id_is_div  input  1  qualifies id_is_md: 1 = divide
id_uses_hilo  input  1  instruction in ID is MFHI/MFLO/MTHI/MTLO
imem_wait  input  1  instruction memory not ready
dmem_wait  input  1  data memory not ready (access in MEM)
PC_Write  output  1  1 = PC loads next value
ifId_Write  output  1  1 = IF/ID register loads
ifId_Flush  output  1  1 = IF/ID loads a NOP
idEx_Bubble  output  1  1 = ID/EX loads a NOP
back_Write  output  1  1 = ID/EX, EX/MEM, MEM/WB advance
md_issue  output  1  one-cycle start pulse to the mult/div unit
md_busy  output  1  mult/div unit occupied
stall_cycles  output  16  saturating count of cycles with PC_Write=0

Behaviour:
- All enable outputs are active-high (1 = advance); combinational from registered state plus current inputs.
- States: RUN, MD_BUSY (encoded by md_count != 0), plus freeze overlay for memory waits.
- Priority, highest first: reset > dmem_wait > front stall > redirect > normal.
- reset=1: PC_Write=0, ifId_Write=0, ifId_Flush=1, idEx_Bubble=1, back_Write=0, md_issue=0. Next edge: md_count=0, md_busy=0, stall_cycles=0.
- dmem_wait=1 (full freeze): PC_Write=0, ifId_Write=0, back_Write=0, ifId_Flush=0, idEx_Bubble=0, md_issue=0. Redirect is held off, not lost; ID keeps the branch and it is re-evaluated.
- Front stall condition fs = load_use | (md_busy & (id_is_md | id_uses_hilo)) | imem_wait.
- fs=1, dmem_wait=0: PC_Write=0, ifId_Write=0, idEx_Bubble=1, back_Write=1, ifId_Flush=0. Redirect is suppressed while stalled.
- Normal, redirect=1: PC_Write=1, ifId_Write=1, ifId_Flush=1, idEx_Bubble=0, back_Write=1.
- Normal, no redirect: all write enables 1, flush/bubble 0.
- md_issue = id_is_md & ~md_busy & ~fs & ~dmem_wait & ~reset. On issue edge md_count loads (id_is_div ? DIV_LATENCY : MUL_LATENCY) - 1.
- md_count decrements by 1 every cycle while nonzero, including during dmem_wait and front stalls; it never wraps below 0. md_busy = (md_count != 0).
- An MD op issued at cycle t makes md_busy high for cycles t+1 .. t+L-1. A dependent MFHI/MFLO in ID at t+1 stalls until md_busy falls, then proceeds in cycle t+L.
- stall_cycles increments on each non-reset edge where PC_Write=0, and saturates at 16'hFFFF.
- Reset asserted mid-divide aborts the operation: md_count=0 after that edge, and no further stall results from it.

Test Plan:
- Reset held 2 cycles with dmem_wait=1 -> outputs show the reset values; after release md_busy=0, stall_cycles=0, and all enables=1 with inputs idle.
- load_use=1 for 1 cycle, redirect=1 in the same cycle -> PC_Write=0, ifId_Write=0, idEx_Bubble=1, ifId_Flush=0; next cycle with load_use=0 and redirect=1 -> ifId_Flush=1; stall_cycles=1.
- MULT issued (id_is_md=1, id_is_div=0) then id_uses_hilo=1 next cycle -> md_issue pulses once, md_busy high 3 cycles, PC_Write=0 for 3 cycles, released in the 4th.
- DIV issued with dmem_wait=1 for 10 cycles starting the following cycle -> md_count still reaches 0 exactly 31 cycles after issue; back_Write=0 during the wait only.
- Second id_is_md while busy -> no md_issue until md_busy=0, then exactly one pulse loading the new latency.
- Force stall_cycles near 16'hFFFF (dmem_wait held 65540 cycles) -> stalls at 16'hFFFF, no wrap; reset mid-divide -> md_busy=0 the next cycle.
